// File: rtl/neural_argmax.sv
// Argmax over the ten per-class neuron sums: captures each sum on its valid
// rising edge, scans them one class per cycle, and hands the winner out on a valid/ready port.
module neural_argmax #(
    parameter int N_CLASS = 10,
    parameter int DW      = 26,
    parameter int IW      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CLASS*DW-1:0]   Neuron_Result,
    input  logic [N_CLASS-1:0]      Neuron_Valid,
    input  logic                    Class_Ready,
    output logic [IW-1:0]           Class_Out,
    output logic [DW-1:0]           Max_Score,
    output logic                    Class_Valid,
    output logic                    Overrun
);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam logic [N_CLASS-1:0] ALL_ONES = {N_CLASS{1'b1}};
    localparam logic [IW-1:0]      LAST_IDX = IW'(N_CLASS - 1);
    localparam logic [IW-1:0]      IDX_ONE  = IW'(1);
    localparam logic [IW-1:0]      IDX_ZERO = IW'(0);

    state_e                 state_q, state_d;
    logic [N_CLASS-1:0]     prev_q;
    logic [N_CLASS-1:0]     mask_q, mask_d;
    logic [N_CLASS-1:0]     rise_s;
    logic signed [DW-1:0]   score_q [N_CLASS];
    logic signed [DW-1:0]   score_d [N_CLASS];
    logic signed [DW-1:0]   best_q, best_d;
    logic [IW-1:0]          best_idx_q, best_idx_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [IW-1:0]          class_out_q, class_out_d;
    logic [DW-1:0]          max_score_q, max_score_d;
    logic                   class_valid_q, class_valid_d;
    logic                   overrun_q, overrun_d;
    logic signed [DW-1:0]   cand_s;
    logic                   better_s;

    // A level already high when prev is cleared by reset counts as a rise.
    assign rise_s   = Neuron_Valid & ~prev_q;
    assign cand_s   = score_q[idx_q];
    assign better_s = (cand_s > best_q);

    assign Class_Out   = class_out_q;
    assign Max_Score   = max_score_q;
    assign Class_Valid = class_valid_q;
    assign Overrun     = overrun_q;

    // Next-state logic for capture, sequential compare and output handshake
    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        score_d       = score_q;
        best_d        = best_q;
        best_idx_d    = best_idx_q;
        idx_d         = idx_q;
        class_out_d   = class_out_q;
        max_score_d   = max_score_q;
        class_valid_d = class_valid_q;

        if ((state_q != ST_COLLECT) && (|rise_s)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            ST_COLLECT: begin
                for (int i = 0; i < N_CLASS; i++) begin
                    if (rise_s[i]) begin
                        score_d[i] = Neuron_Result[DW*i +: DW];
                    end else begin
                        score_d[i] = score_q[i];
                    end
                end
                mask_d = mask_q | rise_s;
                // The mask completed on the previous edge; the scan starts with class 0 as incumbent.
                if (mask_q == ALL_ONES) begin
                    state_d    = ST_COMPARE;
                    best_d     = score_q[0];
                    best_idx_d = IDX_ZERO;
                    idx_d      = IDX_ONE;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COMPARE: begin
                if (better_s) begin
                    best_d     = cand_s;
                    best_idx_d = idx_q;
                end else begin
                    best_d     = best_q;
                    best_idx_d = best_idx_q;
                end
                idx_d = idx_q + IDX_ONE;
                if (idx_q == LAST_IDX) begin
                    state_d       = ST_DONE;
                    class_out_d   = better_s ? idx_q : best_idx_q;
                    max_score_d   = better_s ? cand_s : best_q;
                    class_valid_d = 1'b1;
                end else begin
                    state_d = ST_COMPARE;
                end
            end
            ST_DONE: begin
                if (class_valid_q && Class_Ready) begin
                    class_valid_d = 1'b0;
                    mask_d        = '0;
                    state_d       = ST_COLLECT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_COLLECT;
            prev_q        <= '0;
            mask_q        <= '0;
            for (int i = 0; i < N_CLASS; i++) begin
                score_q[i] <= '0;
            end
            best_q        <= '0;
            best_idx_q    <= '0;
            idx_q         <= '0;
            class_out_q   <= '0;
            max_score_q   <= '0;
            class_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_q        <= Neuron_Valid;
            mask_q        <= mask_d;
            for (int i = 0; i < N_CLASS; i++) begin
                score_q[i] <= score_d[i];
            end
            best_q        <= best_d;
            best_idx_q    <= best_idx_d;
            idx_q         <= idx_d;
            class_out_q   <= class_out_d;
            max_score_q   <= max_score_d;
            class_valid_q <= class_valid_d;
            overrun_q     <= overrun_d;
        end
    end

endmodule
